// File: rtl/alu_md_unit_if.sv
// Issue/result handshake bundle for alu_md_unit: operands and decode fields in,
// registered result and zero flag out, each side with its own valid/ready pair.
interface alu_md_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] operand_a;
  logic [N-1:0] operand_b;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [6:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;

  modport master (
    output in_valid, operand_a, operand_b, funct3, funct7, opcode, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, operand_a, operand_b, funct3, funct7, opcode, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with a registered result; defining ALU_MEXT_EN adds an
// iterative RV32M multiply/divide engine (shift-add / restoring, N+2 cycle latency).
module alu_md_unit #(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_md_unit_if.slave  bus,
  output logic          busy
);

  localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
  localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE        = 7'b0000000;
  localparam logic [6:0] F7_ALT         = 7'b0100000;

  function automatic logic [N-1:0] base_op(input logic [2:0] f3, input logic alt,
                                           input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    logic [SHAMT_W-1:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[SHAMT_W-1:0];
    case (f3)
      3'b000:  base_op = alt ? a - b : a + b;
      3'b001:  base_op = a << sh;
      3'b010:  base_op = {{(N-1){1'b0}}, (sa < sb)};
      3'b011:  base_op = {{(N-1){1'b0}}, (a < b)};
      3'b100:  base_op = a ^ b;
      3'b101:  base_op = alt ? $unsigned(sa >>> sh) : (a >> sh);
      3'b110:  base_op = a | b;
      default: base_op = a & b;
    endcase
  endfunction

  logic         dec_legal;
  logic         dec_alt;
  logic         dec_m;
  logic         accept;
  logic [N-1:0] base_res;
  logic         wr_en;
  logic [N-1:0] wr_val;
  logic         vld_p1;
  logic [N-1:0] result_p1;
  logic         zero_p1;

  // Immediate shifts keep funct7 as a real field; other immediates ignore it.
  always_comb begin
    dec_legal = 1'b0;
    dec_alt   = 1'b0;
    dec_m     = 1'b0;
    if (bus.opcode == OPCODE_REG_REG) begin
      if (bus.funct7 == F7_BASE) begin
        dec_legal = 1'b1;
      end else if (bus.funct7 == F7_ALT && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101)) begin
        dec_legal = 1'b1;
        dec_alt   = 1'b1;
      end
`ifdef ALU_MEXT_EN
      else if (bus.funct7 == 7'b0000001) begin
        dec_m = 1'b1;
      end
`endif
    end else if (bus.opcode == OPCODE_REG_IMM) begin
      if (bus.funct3 == 3'b001) begin
        dec_legal = (bus.funct7 == F7_BASE);
      end else if (bus.funct3 == 3'b101) begin
        dec_legal = (bus.funct7 == F7_BASE) || (bus.funct7 == F7_ALT);
        dec_alt   = (bus.funct7 == F7_ALT);
      end else begin
        dec_legal = 1'b1;
      end
    end
  end

  assign base_res = dec_legal ? base_op(bus.funct3, dec_alt, bus.operand_a, bus.operand_b) : '0;
  assign accept   = bus.in_valid && bus.in_ready;

`ifdef ALU_MEXT_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SHAMT_W-1:0] cnt_p1;
  logic [N-1:0]       hi_p1;
  logic [N-1:0]       lo_p1;
  logic [N-1:0]       mcand_p1;
  logic [N-1:0]       opa_p1;
  logic [2:0]         op_p1;
  logic               neg_p1;
  logic               rneg_p1;
  logic               dz_p1;
  logic               a_neg;
  logic               b_neg;
  logic [N-1:0]       mag_a;
  logic [N-1:0]       mag_b;
  logic [N:0]         mul_sum;
  logic [N:0]         div_shift;
  logic [N:0]         div_diff;
  logic               div_ge;
  logic [2*N-1:0]     prod_fix;
  logic [N-1:0]       fix_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (accept && dec_m) state_d = bus.funct3[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt_p1 == '0) state_d = S_FIX;
      S_FIX:        state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign busy         = (state_q != S_IDLE);
  assign bus.in_ready = !busy && (!vld_p1 || bus.out_ready);

  // Operand signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u; DIV/REM signed, DIVU/REMU unsigned.
  always_comb begin
    a_neg = bus.operand_a[N-1] && (bus.funct3[2] ? !bus.funct3[0] : (bus.funct3 != 3'b011));
    b_neg = bus.operand_b[N-1] && (bus.funct3[2] ? !bus.funct3[0] : !bus.funct3[1]);
    mag_a = a_neg ? -bus.operand_a : bus.operand_a;
    mag_b = b_neg ? -bus.operand_b : bus.operand_b;
  end

  assign mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, mcand_p1} : '0);
  assign div_shift = {hi_p1, lo_p1[N-1]};
  assign div_diff  = div_shift - {1'b0, mcand_p1};
  assign div_ge    = (div_shift >= {1'b0, mcand_p1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1   <= '0;
      hi_p1    <= '0;
      lo_p1    <= '0;
      mcand_p1 <= '0;
      opa_p1   <= '0;
      op_p1    <= '0;
      neg_p1   <= 1'b0;
      rneg_p1  <= 1'b0;
      dz_p1    <= 1'b0;
    end else if (flush) begin
      cnt_p1 <= '0;
    end else if (accept && dec_m) begin
      cnt_p1   <= SHAMT_W'(N - 1);
      hi_p1    <= '0;
      lo_p1    <= bus.funct3[2] ? mag_a : mag_b;
      mcand_p1 <= bus.funct3[2] ? mag_b : mag_a;
      opa_p1   <= bus.operand_a;
      op_p1    <= bus.funct3;
      neg_p1   <= a_neg ^ b_neg;
      rneg_p1  <= a_neg;
      dz_p1    <= (bus.operand_b == '0);
    end else if (state_q == S_MUL) begin
      {hi_p1, lo_p1} <= {mul_sum, lo_p1[N-1:1]};
      if (cnt_p1 != '0) cnt_p1 <= cnt_p1 - 1'b1;
    end else if (state_q == S_DIV) begin
      hi_p1 <= div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
      lo_p1 <= {lo_p1[N-2:0], div_ge};
      if (cnt_p1 != '0) cnt_p1 <= cnt_p1 - 1'b1;
    end
  end

  // Sign correction; divide-by-zero bypasses it since magnitudes say nothing useful there.
  always_comb begin
    prod_fix = neg_p1 ? -{hi_p1, lo_p1} : {hi_p1, lo_p1};
    fix_res  = '0;
    case (op_p1)
      3'b000:         fix_res = prod_fix[N-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = prod_fix[2*N-1:N];
      3'b100, 3'b101: fix_res = dz_p1 ? '1 : (neg_p1 ? -lo_p1 : lo_p1);
      default:        fix_res = dz_p1 ? opa_p1 : (rneg_p1 ? -hi_p1 : hi_p1);
    endcase
  end

  always_comb begin
    wr_en  = accept && !dec_m;
    wr_val = base_res;
    if (state_q == S_FIX) begin
      wr_en  = 1'b1;
      wr_val = fix_res;
    end
  end
`else
  assign busy         = 1'b0;
  assign bus.in_ready = !vld_p1 || bus.out_ready;

  always_comb begin
    wr_en  = accept && !dec_m;
    wr_val = base_res;
  end
`endif

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      zero_p1   <= 1'b1;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (wr_en) begin
      vld_p1    <= 1'b1;
      result_p1 <= wr_val;
      zero_p1   <= (wr_val == '0);
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.result    = result_p1;
  assign bus.zero      = zero_p1;

endmodule

// File: tb/tb_alu_md_unit.sv
// Randomised self-checking bench for alu_md_unit: a behavioural RV32I/M model
// feeds a scoreboard that checks result, zero, latency, busy and in_ready each cycle.
module tb_alu_md_unit;
  localparam int N = 32;
  localparam logic [6:0] RR = 7'h33;
  localparam logic [6:0] RI = 7'h13;
`ifdef ALU_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  alu_md_unit_if #(.N(N)) bus ();

  alu_md_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    bit          seen;
    bit          late;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] f3, input bit alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] mext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb2;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb2));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb2));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] a, input logic [31:0] b, output int lat);
    lat = 1;
    if (opc == RR) begin
      if (f7 == 7'h00) return alu(f3, 1'b0, a, b);
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return alu(f3, 1'b1, a, b);
      if (f7 == 7'h01 && MEXT) begin lat = N + 2; return mext(f3, a, b); end
      return 32'd0;
    end
    if (opc == RI) begin
      if (f3 == 3'd1) return (f7 == 7'h00) ? alu(f3, 1'b0, a, b) : 32'd0;
      if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? alu(f3, f7 == 7'h20, a, b) : 32'd0;
      return alu(f3, 1'b0, a, b);
    end
    return 32'd0;
  endfunction

  // Scoreboard / compare process, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_busy = (sb.size() > 0) && (sb[0].lat > 1) && (cyc > sb[0].acc) && (cyc < sb[0].acc + sb[0].lat);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !exp_busy && (!bus.out_valid || bus.out_ready)});
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!sb[0].seen) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            sb[0].seen = 1'b1;
          end
          chk("result", bus.result, sb[0].res);
          chk("zero", {31'd0, bus.zero}, {31'd0, sb[0].res == 32'd0});
          if (bus.out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && !sb[0].late && (cyc - sb[0].acc > sb[0].lat)) begin
        sb[0].late = 1'b1;
        chk("result_late", 32'd0, 32'd1);
      end
      if (flush) begin
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e.res  = model(bus.opcode, bus.funct3, bus.funct7, bus.operand_a, bus.operand_b, e.lat);
        e.acc  = cyc;
        e.seen = 1'b0;
        e.late = 1'b0;
        sb.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Returns 2 time units after the accepting edge, with in_valid dropped.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    int bound;
    bus.in_valid  = 1'b1;
    bus.opcode    = opc;
    bus.funct3    = f3;
    bus.funct7    = f7;
    bus.operand_a = a;
    bus.operand_b = b;
    bound = 0;
    @(negedge clk);
    while (!bus.in_ready && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 200) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int          lat;
    int          bound;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.opcode    = RR;

    step(3);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    chk("pin_add", model(RR, 3'd0, 7'h00, 32'd5, 32'd7, lat), 32'd12);
    chk("pin_sub", model(RR, 3'd0, 7'h20, 32'd5, 32'd7, lat), 32'hFFFF_FFFE);
    chk("pin_slt", model(RR, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, lat), 32'd1);
    chk("pin_sltu", model(RR, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, lat), 32'd0);
    chk("pin_sra", model(RR, 3'd5, 7'h20, 32'h8000_0000, 32'd4, lat), 32'hF800_0000);
    chk("pin_srai", model(RI, 3'd5, 7'h20, 32'h8000_0000, 32'd4, lat), 32'hF800_0000);
    chk("pin_addi_f7", model(RI, 3'd0, 7'h20, 32'd5, 32'd7, lat), 32'd12);
    chk("pin_bad_opc", model(7'h03, 3'd0, 7'h00, 32'd5, 32'd7, lat), 32'd0);
`ifdef ALU_MEXT_EN
    chk("pin_mulh", model(RR, 3'd1, 7'h01, 32'h8000_0000, 32'd2, lat), 32'hFFFF_FFFF);
    chk("pin_mulh_lat", lat, 34);
    chk("pin_mulhu", model(RR, 3'd3, 7'h01, 32'h8000_0000, 32'd2, lat), 32'd1);
    chk("pin_div_ovf", model(RR, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, lat), 32'h8000_0000);
    chk("pin_divu_0", model(RR, 3'd5, 7'h01, 32'd7, 32'd0, lat), 32'hFFFF_FFFF);
    chk("pin_rem", model(RR, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, lat), 32'hFFFF_FFFF);
    chk("pin_remu_0", model(RR, 3'd7, 7'h01, 32'd7, 32'd0, lat), 32'd7);
`else
    chk("pin_mext_off", model(RR, 3'd0, 7'h01, 32'd5, 32'd7, lat), 32'd0);
    chk("pin_mext_off_lat", lat, 1);
`endif

    // back-to-back ADD then SUB
    send(RR, 3'd0, 7'h00, 32'd5, 32'd7);
    chk("add_direct", bus.result, 32'd12);
    send(RR, 3'd0, 7'h20, 32'd5, 32'd7);
    chk("sub_direct", bus.result, 32'hFFFF_FFFE);
    chk("sub_zero", {31'd0, bus.zero}, 32'd0);
    send(RR, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1);
    send(RR, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1);
    send(RR, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    send(RI, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    chk("srai_direct", bus.result, 32'hF800_0000);
    send(RR, 3'd0, 7'h01, 32'd3, 32'd4);

    // output stall
    step(40);
    bus.out_ready = 1'b0;
    send(RR, 3'd0, 7'h00, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_result", bus.result, 32'd2);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step(1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step(1);
    chk("unstall_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef ALU_MEXT_EN
    send(RR, 3'd1, 7'h01, 32'h8000_0000, 32'd2);
    chk("mulh_busy", {31'd0, busy}, 32'd1);
    chk("mulh_in_ready", {31'd0, bus.in_ready}, 32'd0);
    send(RR, 3'd3, 7'h01, 32'h8000_0000, 32'd2);
    send(RR, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    send(RR, 3'd5, 7'h01, 32'd7, 32'd0);
    send(RR, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2);
    send(RR, 3'd7, 7'h01, 32'd7, 32'd0);
    step(40);
    send(RR, 3'd4, 7'h01, 32'd100, 32'd7);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_div_busy", {31'd0, busy}, 32'd0);
    chk("flush_div_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_div_in_ready", {31'd0, bus.in_ready}, 32'd1);
`endif

    // flush of a held result
    bus.out_ready = 1'b0;
    send(RR, 3'd0, 7'h00, 32'd3, 32'd4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;

    // asynchronous reset in the middle of an op (MUL when enabled)
    bus.out_ready = 1'b0;
    send(RR, 3'd0, MEXT ? 7'h01 : 7'h00, 32'd3, 32'd5);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_zero", {31'd0, bus.zero}, 32'd1);
    chk("arst_result", bus.result, 32'd0);
    step(1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step(1);

    // randomised traffic with random downstream back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       opc = 7'($urandom);
        1, 2, 3, 4: opc = RI;
        default: opc = RR;
      endcase
      case ($urandom_range(0, 5))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        3, 4:    f7 = (opc == RI) ? 7'h00 : 7'h01;
        default: f7 = (opc == RI) ? 7'h20 : 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000 >> $urandom_range(0, 1);
        1:       a = $urandom_range(0, 9) - 5;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      send(opc, 3'($urandom), f7, a, b);
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    bound = 0;
    while (sb.size() != 0 && bound < 100) begin
      step(1);
      bound++;
    end
    chk("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
